// File: rtl/reg_wb_pkg.sv
// Shared writeback types: register/data widths, queue entry and register-file write bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package reg_wb_pkg;

    localparam int REG_W    = 4;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 1 << REG_W;

    // One outstanding load: destination, data-arrived flag, returned data.
    typedef struct packed {
        logic [REG_W-1:0]  reg_idx;
        logic              filled;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // One register-file write port transaction.
    typedef struct packed {
        logic              write;
        logic [REG_W-1:0]  reg_idx;
        logic [DATA_W-1:0] data;
    } wb_write_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_W-1:0] r);
        logic [NUM_REGS-1:0] one;
        one = {{(NUM_REGS-1){1'b0}}, 1'b1};
        return one << r;
    endfunction

endpackage

// File: rtl/reg_wb_queue.sv
// In-order outstanding-load queue: allocate at tail, fill oldest unfilled, retire at head.
// Latency: entry fillable the cycle after allocation; a same-cycle fill of the head is offered for retire.
// Backpressure: ld_full blocks allocation (from registered count); mem_ready gates fills.
module reg_wb_queue
    import reg_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alloc_req,
    input  logic [REG_W-1:0]    alloc_reg,
    input  logic                fill_req,
    input  logic [DATA_W-1:0]   fill_data,
    input  logic                retire_en,
    output logic                ld_full,
    output logic                mem_ready,
    output logic                head_rdy,
    output logic [REG_W-1:0]    head_reg,
    output logic [DATA_W-1:0]   head_data,
    output logic [NUM_REGS-1:0] pending
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t [DEPTH-1:0] ent_q;
    logic [DEPTH-1:0]      vld_q;
    logic [PTR_W-1:0]      alloc_ptr_q;
    logic [PTR_W-1:0]      fill_ptr_q;
    logic [PTR_W-1:0]      ret_ptr_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      ucnt_q;

    logic alloc_do;
    logic fill_do;
    logic fill_bypass;
    logic retire_do;

    assign ld_full   = (cnt_q == CNT_W'(DEPTH));
    assign mem_ready = (ucnt_q != '0);
    assign alloc_do  = alloc_req && !ld_full;
    assign fill_do   = fill_req && mem_ready;

    // A fill landing on the head entry makes it retirable in the same cycle,
    // so load data reaches the write port one cycle after the return.
    assign fill_bypass = fill_do && (fill_ptr_q == ret_ptr_q);
    assign head_rdy    = vld_q[ret_ptr_q] && (ent_q[ret_ptr_q].filled || fill_bypass);
    assign head_reg    = ent_q[ret_ptr_q].reg_idx;
    assign head_data   = ent_q[ret_ptr_q].filled ? ent_q[ret_ptr_q].data : fill_data;
    assign retire_do   = retire_en && head_rdy;

    // Entry storage, pointers and occupancy counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent_q       <= '0;
            vld_q       <= '0;
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            ret_ptr_q   <= '0;
            cnt_q       <= '0;
            ucnt_q      <= '0;
        end else begin
            if (alloc_do) begin
                ent_q[alloc_ptr_q].reg_idx <= alloc_reg;
                ent_q[alloc_ptr_q].filled  <= 1'b0;
                vld_q[alloc_ptr_q]         <= 1'b1;
                alloc_ptr_q                <= alloc_ptr_q + PTR_W'(1);
            end
            if (fill_do) begin
                ent_q[fill_ptr_q].data   <= fill_data;
                ent_q[fill_ptr_q].filled <= 1'b1;
                fill_ptr_q               <= fill_ptr_q + PTR_W'(1);
            end
            // Retire last: a bypassed fill of the head must leave the slot clean.
            if (retire_do) begin
                ent_q[ret_ptr_q].filled <= 1'b0;
                vld_q[ret_ptr_q]        <= 1'b0;
                ret_ptr_q               <= ret_ptr_q + PTR_W'(1);
            end
            cnt_q  <= cnt_q + CNT_W'(alloc_do) - CNT_W'(retire_do);
            ucnt_q <= ucnt_q + CNT_W'(alloc_do) - CNT_W'(fill_do);
        end
    end

    // Pending mask: OR of destination one-hots over live entries (flop-derived only).
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i]) begin
                pending = pending | reg_onehot(ent_q[i].reg_idx);
            end
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// Merges execute results and in-order load returns into one register-file write port; tracks hazards.
// Latency: 1 cycle to write (0 with REG_WB_COMB_OUT_EN defined); pending and err always registered.
// Backpressure: none on execute; loads stall via ld_full, returns via mem_ready; violations set sticky err.
module reg_writeback
    import reg_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ex_valid,
    input  logic [REG_W-1:0]    ex_reg,
    input  logic [DATA_W-1:0]   ex_data,
    input  logic                ld_issue,
    input  logic [REG_W-1:0]    ld_issue_reg,
    output logic                ld_full,
    input  logic                mem_valid,
    input  logic [DATA_W-1:0]   mem_data,
    output logic                mem_ready,
    output logic                write,
    output logic [REG_W-1:0]    write_reg,
    output logic [DATA_W-1:0]   write_data,
    output logic [NUM_REGS-1:0] pending,
    output logic                err
);

    logic              head_rdy;
    logic [REG_W-1:0]  head_reg;
    logic [DATA_W-1:0] head_data;
    wb_write_t         wb_nxt;
    logic              err_q;

    reg_wb_queue #(.DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .alloc_req (ld_issue),
        .alloc_reg (ld_issue_reg),
        .fill_req  (mem_valid),
        .fill_data (mem_data),
        .retire_en (!ex_valid),
        .ld_full   (ld_full),
        .mem_ready (mem_ready),
        .head_rdy  (head_rdy),
        .head_reg  (head_reg),
        .head_data (head_data),
        .pending   (pending)
    );

    // Fixed-priority arbitration: execute result first, then a retirable load head.
    always_comb begin
        wb_nxt = '0;
        if (!rst) begin
            if (ex_valid) begin
                wb_nxt = '{write: 1'b1, reg_idx: ex_reg, data: ex_data};
            end else if (head_rdy) begin
                wb_nxt = '{write: 1'b1, reg_idx: head_reg, data: head_data};
            end
        end
    end

`ifdef REG_WB_COMB_OUT_EN
    assign write      = wb_nxt.write;
    assign write_reg  = wb_nxt.reg_idx;
    assign write_data = wb_nxt.data;
`else
    wb_write_t wb_q;

    // Register the arbitration result onto the write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q <= '0;
        end else begin
            wb_q <= wb_nxt;
        end
    end

    assign write      = wb_q.write;
    assign write_reg  = wb_q.reg_idx;
    assign write_data = wb_q.data;
`endif

    // Sticky protocol error: dropped issue, unexpected return, or WAW against a pending load.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_q
                   | (ld_issue && ld_full)
                   | (mem_valid && !mem_ready)
                   | (ex_valid && pending[ex_reg]);
        end
    end

    assign err = err_q;

endmodule
